program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time loader directly upstream of the CPU state controller.
- After reset it sends 0x99 to the host over the UART transmitter, then receives a 4-byte program size and the program image byte by byte from the UART receiver.
- It packs the bytes into 32-bit words, writes them into program memory and sends 0xAA.
- It drives the two fetch-finished flags the state controller consumes.

Parameters:
- ADDR_WIDTH, 14, width of the program memory word address; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- tx_ready  input  1  UART transmitter can accept a byte this cycle.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid; the byte transfers when tx_valid && tx_ready.
- prog_mem_addr  output  ADDR_WIDTH  word address for the program memory write.
- prog_mem_wdata  output  32  assembled instruction word.
- prog_mem_wren  output  1  one-cycle program memory write strobe.
- program_data_size_fetch_finished  output  1  sticky; the 4 size bytes have been received.
- program_data_fetch_finished  output  1  sticky; the image is written and 0xAA has been sent.

Behaviour:
- All outputs are registered. Reset applies on a clk edge with reset=1 and takes priority over all other activity.
- Reset values:
  - tx_data=0x00, tx_valid=0, prog_mem_wren=0.
  - prog_mem_addr=0, prog_mem_wdata=0.
  - Both finished flags=0.
  - state=SEND_99; byte counter, size register and word shift register cleared.
- Reset mid-operation aborts the transfer and the sequence restarts at SEND_99. Words already written are not erased.
- SEND_99:
  - tx_data=0x99, tx_valid=1 from the first cycle after reset release.
  - Hold both until a cycle with tx_ready=1. tx_valid drops the next cycle; go to RECV_SIZE.
- RECV_SIZE:
  - Collect 4 bytes, little-endian, into size[31:0]. size is a byte count.
  - The cycle after the 4th byte's rx_valid, program_data_size_fetch_finished rises.
  - If size==0 go to SEND_AA, otherwise go to RECV_DATA.
- RECV_DATA:
  - Each rx_valid byte is shifted into a word, little-endian (first byte lands in [7:0]).
  - After every 4th byte: the next cycle prog_mem_wren=1 for exactly one cycle, prog_mem_wdata=the word, prog_mem_addr=word index (0,1,2,...).
  - When the total received count equals size:
    - If size mod 4 != 0, the final partial word is written zero-padded in the upper bytes, the cycle after the last byte.
    - Then go to SEND_AA.
  - Words with index >= 2^ADDR_WIDTH are consumed and counted but never written (wren suppressed, address does not wrap).
- SEND_AA:
  - Same handshake as SEND_99 with tx_data=0xAA.
  - Entered no earlier than the cycle after the last prog_mem_wren.
  - On transfer, program_data_fetch_finished rises the next cycle; go to DONE.
- DONE:
  - Terminal state. Flags stay high and rx_valid is ignored until reset.
- rx_valid while in SEND_99, SEND_AA or DONE is dropped.
- The block never needs two bytes in consecutive cycles, but it must accept rx_valid in back-to-back cycles without loss.
- Byte and word counters are 32 bits wide; size up to 2^32-1 is accepted.

Test Plan:
- Reset, tx_ready=1 -> tx_valid=1 with tx_data=0x99 for exactly one cycle. Then send size bytes 08 00 00 00 -> size flag rises one cycle after the 4th byte. Then data bytes 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093. Then 0xAA is transmitted and program_data_fetch_finished rises.
- tx_ready held low for 20 cycles in SEND_99 -> tx_valid=1 and tx_data=0x99 stable throughout. Raise tx_ready -> exactly one transfer.
- Size 0 -> no prog_mem_wren; 0xAA is sent immediately after the size flag rises.
- Size 6 with bytes 01..06 -> addr0=0x04030201, addr1=0x00000605.
- ADDR_WIDTH=2, size 24 -> only addrs 0..3 are written, 6 words are consumed, then 0xAA is sent.
- Reset asserted after 2 data bytes -> flags clear and 0x99 is sent again. Rx bytes arriving during SEND_99 cause no writes.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: handshakes with the host over UART, receives a
// byte-counted program image and writes it into program memory as 32-bit words.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic [ADDR_WIDTH-1:0] prog_mem_addr,
    output logic [31:0]           prog_mem_wdata,
    output logic                  prog_mem_wren,
    output logic                  program_data_size_fetch_finished,
    output logic                  program_data_fetch_finished
);

    localparam logic [7:0] BOOT_BYTE = 8'h99;
    localparam logic [7:0] DONE_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        S_SEND_99,
        S_RECV_SIZE,
        S_RECV_DATA,
        S_SEND_AA,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wren;
    logic                  r_size_done;
    logic                  r_fetch_done;
    logic [31:0]           r_byte_cnt;
    logic [31:0]           r_size;
    logic [31:0]           r_word;
    logic [31:0]           r_word_idx;

    logic [31:0]           w_size_next;
    logic [31:0]           w_cnt_inc;
    logic [31:0]           w_word_merged;
    logic                  w_word_full;
    logic                  w_last;
    logic                  w_addr_ok;

    assign tx_data                          = r_tx_data;
    assign tx_valid                         = r_tx_valid;
    assign prog_mem_addr                    = r_addr;
    assign prog_mem_wdata                   = r_wdata;
    assign prog_mem_wren                    = r_wren;
    assign program_data_size_fetch_finished = r_size_done;
    assign program_data_fetch_finished      = r_fetch_done;

    // Size arrives little-endian: shift each new byte in from the top.
    assign w_size_next = {rx_data, r_size[31:8]};
    assign w_cnt_inc   = r_byte_cnt + 32'd1;
    assign w_word_full = (r_byte_cnt[1:0] == 2'd3);
    assign w_last      = (w_cnt_inc == r_size);
    // Words past the end of memory are consumed but never written.
    assign w_addr_ok   = ((r_word_idx >> ADDR_WIDTH) == 32'd0);

    // Byte lane placement keeps a partial final word zero-padded at the top.
    always_comb begin
        w_word_merged = r_word;
        case (r_byte_cnt[1:0])
            2'd0:    w_word_merged[7:0]   = rx_data;
            2'd1:    w_word_merged[15:8]  = rx_data;
            2'd2:    w_word_merged[23:16] = rx_data;
            default: w_word_merged[31:24] = rx_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_SEND_99;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_wren       <= 1'b0;
            r_size_done  <= 1'b0;
            r_fetch_done <= 1'b0;
            r_byte_cnt   <= 32'd0;
            r_size       <= 32'd0;
            r_word       <= 32'd0;
            r_word_idx   <= 32'd0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_SEND_99: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= BOOT_BYTE;
                    end else if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_RECV_SIZE;
                    end
                end

                S_RECV_SIZE: begin
                    if (rx_valid) begin
                        r_size <= w_size_next;
                        if (r_byte_cnt[1:0] == 2'd3) begin
                            r_byte_cnt  <= 32'd0;
                            r_size_done <= 1'b1;
                            if (w_size_next == 32'd0) begin
                                r_state    <= S_SEND_AA;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= DONE_BYTE;
                            end else begin
                                r_state <= S_RECV_DATA;
                            end
                        end else begin
                            r_byte_cnt <= w_cnt_inc;
                        end
                    end
                end

                S_RECV_DATA: begin
                    if (rx_valid) begin
                        r_byte_cnt <= w_cnt_inc;
                        if (w_word_full || w_last) begin
                            r_wren <= w_addr_ok;
                            if (w_addr_ok) begin
                                r_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                                r_wdata <= w_word_merged;
                            end
                            r_word     <= 32'd0;
                            r_word_idx <= r_word_idx + 32'd1;
                        end else begin
                            r_word <= w_word_merged;
                        end
                        // tx_valid is raised one cycle later, clear of the final write.
                        if (w_last) begin
                            r_state <= S_SEND_AA;
                        end
                    end
                end

                S_SEND_AA: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= DONE_BYTE;
                    end else if (tx_ready) begin
                        r_tx_valid   <= 1'b0;
                        r_fetch_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                end

                default: r_state <= S_SEND_99;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of complete load transactions plus
// hand-written sequences for stalls, mid-load reset, memory overflow and DONE.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [13:0] prog_mem_addr;
    logic [31:0] prog_mem_wdata;
    logic        prog_mem_wren;
    logic        size_flag;
    logic        done_flag;

    logic [7:0]  s_tx_data;
    logic        s_tx_valid;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_wren;
    logic        s_size_flag;
    logic        s_done_flag;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  tx_q_s[$];
    logic [31:0] wa_q_s[$];
    logic [31:0] wd_q_s[$];

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(14)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .rx_data                          (rx_data),
        .rx_valid                         (rx_valid),
        .tx_ready                         (tx_ready),
        .tx_data                          (tx_data),
        .tx_valid                         (tx_valid),
        .prog_mem_addr                    (prog_mem_addr),
        .prog_mem_wdata                   (prog_mem_wdata),
        .prog_mem_wren                    (prog_mem_wren),
        .program_data_size_fetch_finished (size_flag),
        .program_data_fetch_finished      (done_flag)
    );

    program_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk                              (clk),
        .reset                            (reset),
        .rx_data                          (rx_data),
        .rx_valid                         (rx_valid),
        .tx_ready                         (tx_ready),
        .tx_data                          (s_tx_data),
        .tx_valid                         (s_tx_valid),
        .prog_mem_addr                    (s_addr),
        .prog_mem_wdata                   (s_wdata),
        .prog_mem_wren                    (s_wren),
        .program_data_size_fetch_finished (s_size_flag),
        .program_data_fetch_finished      (s_done_flag)
    );

    // Record handshakes and writes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (prog_mem_wren) begin
            wa_q.push_back(32'(prog_mem_addr));
            wd_q.push_back(prog_mem_wdata);
        end
        if (s_tx_valid && tx_ready) tx_q_s.push_back(s_tx_data);
        if (s_wren) begin
            wa_q_s.push_back(32'(s_addr));
            wd_q_s.push_back(s_wdata);
        end
        if (prog_mem_wren && tx_valid) overlap++;
    end

    typedef struct {
        logic [31:0] size;
        int          nbytes;
        logic [63:0] dat;
        int          gap;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        tx_q.delete(); wa_q.delete(); wd_q.delete();
        tx_q_s.delete(); wa_q_s.delete(); wd_q_s.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset_state",
            64'({tx_valid, tx_data, prog_mem_wren, prog_mem_addr, prog_mem_wdata, size_flag, done_flag}),
            64'd0);
        @(posedge clk); #1;
        clear_q();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_tx(input logic [7:0] exp, input string name, input logic exp_done);
        int  n0;
        bit  got;
        n0  = tx_q.size();
        got = 1'b0;
        tx_ready = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk); #1;
            if (tx_q.size() > n0) got = 1'b1;
        end
        tx_ready = 1'b0;
        chk({name, "_tx_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({name, "_tx_byte"}, 64'(tx_q[n0]), 64'(exp));
            chk({name, "_tx_drop"}, 64'(tx_valid), 64'd0);
            chk({name, "_done_flag"}, 64'(done_flag), 64'(exp_done));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_w;
        do_reset();
        wait_tx(8'h99, $sformatf("v%0d_boot", idx), 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(v.size >> (8 * i)), v.gap);
            chk($sformatf("v%0d_size_flag%0d", idx, i), 64'(size_flag), 64'(i == 3));
        end
        if (v.size == 32'd0)
            chk($sformatf("v%0d_aa_immediate", idx), 64'({tx_valid, tx_data}), 64'({1'b1, 8'hAA}));
        for (int i = 0; i < v.nbytes; i++)
            send_byte(8'(v.dat >> (8 * i)), v.gap);
        wait_tx(8'hAA, $sformatf("v%0d_end", idx), 1'b1);
        chk($sformatf("v%0d_nwr", idx), 64'(wd_q.size()), 64'(v.nwr));
        for (int k = 0; k < wd_q.size() && k < 2; k++) begin
            exp_w = (k == 0) ? v.w0 : v.w1;
            chk($sformatf("v%0d_addr%0d", idx, k), 64'(wa_q[k]), 64'(k));
            chk($sformatf("v%0d_data%0d", idx, k), 64'(wd_q[k]), 64'(exp_w));
        end
        chk($sformatf("v%0d_tx_count", idx), 64'(tx_q.size()), 64'd2);
    endtask

    initial begin
        logic        stable;
        logic [31:0] exp_w;

        tbl[0] = '{size:32'd8, nbytes:8, dat:64'h00100093_00000013, gap:0, nwr:2,
                   w0:32'h00000013, w1:32'h00100093};
        tbl[1] = '{size:32'd6, nbytes:6, dat:64'h00000605_04030201, gap:1, nwr:2,
                   w0:32'h04030201, w1:32'h00000605};
        tbl[2] = '{size:32'd0, nbytes:0, dat:64'h0, gap:0, nwr:0,
                   w0:32'h0, w1:32'h0};
        tbl[3] = '{size:32'd1, nbytes:1, dat:64'hAB, gap:0, nwr:1,
                   w0:32'h000000AB, w1:32'h0};
        tbl[4] = '{size:32'd3, nbytes:3, dat:64'h332211, gap:1, nwr:1,
                   w0:32'h00332211, w1:32'h0};
        tbl[5] = '{size:32'd7, nbytes:7, dat:64'h00070605_04030201, gap:0, nwr:2,
                   w0:32'h04030201, w1:32'h00070605};
        tbl[6] = '{size:32'd8, nbytes:8, dat:64'h04030201_EFBEADDE, gap:1, nwr:2,
                   w0:32'hEFBEADDE, w1:32'h04030201};

        for (int t = 0; t < 7; t++) run_vec(tbl[t], t);

        // DONE ignores further receive traffic.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_no_write", 64'(wd_q.size()), 64'd2);
        chk("done_flags", 64'({size_flag, done_flag}), 64'h3);
        chk("done_no_tx", 64'(tx_q.size() + 32'(tx_valid)), 64'd2);

        // Boot byte held stable while the transmitter stalls.
        do_reset();
        @(posedge clk); #1;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!(tx_valid && tx_data == 8'h99)) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("stall_stable", 64'(stable), 64'd1);
        chk("stall_no_tx", 64'(tx_q.size()), 64'd0);
        wait_tx(8'h99, "stall", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_one_transfer", 64'(tx_q.size()), 64'd1);

        // Reset in the middle of the image restarts the handshake.
        do_reset();
        wait_tx(8'h99, "mid_boot", 1'b0);
        send_byte(8'd8, 0); send_byte(8'd0, 0); send_byte(8'd0, 0); send_byte(8'd0, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_flags", 64'({size_flag, done_flag, tx_valid}), 64'd0);
        clear_q();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 0);
        chk("mid_send99_drop", 64'({size_flag, 32'(wd_q.size())}), 64'd0);
        chk("mid_send99_hold", 64'({tx_valid, tx_data}), 64'({1'b1, 8'h99}));
        wait_tx(8'h99, "mid_reboot", 1'b0);
        send_byte(8'd4, 0); send_byte(8'd0, 0); send_byte(8'd0, 0); send_byte(8'd0, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        wait_tx(8'hAA, "mid_end", 1'b1);
        chk("mid_nwr", 64'(wd_q.size()), 64'd1);
        if (wd_q.size() > 0)
            chk("mid_word", 64'({wa_q[0], wd_q[0]}), 64'({32'd0, 32'hDEADBEEF}));

        // Image larger than a 4-word memory: extra words consumed, not written.
        do_reset();
        wait_tx(8'h99, "ovf_boot", 1'b0);
        send_byte(8'd24, 0); send_byte(8'd0, 0); send_byte(8'd0, 0); send_byte(8'd0, 0);
        for (int i = 0; i < 24; i++) send_byte(8'(i + 1), 0);
        wait_tx(8'hAA, "ovf_end", 1'b1);
        chk("ovf_big_nwr", 64'(wd_q.size()), 64'd6);
        chk("ovf_small_nwr", 64'(wd_q_s.size()), 64'd4);
        for (int k = 0; k < wd_q_s.size() && k < 4; k++) begin
            exp_w = {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
            chk($sformatf("ovf_small_w%0d", k), 64'({wa_q_s[k], wd_q_s[k]}), 64'({32'(k), exp_w}));
        end
        if (wd_q.size() == 6)
            chk("ovf_big_w5", 64'({wa_q[5], wd_q[5]}), 64'({32'd5, 32'h18171615}));
        chk("ovf_small_tx", 64'({32'(tx_q_s.size()), s_done_flag}), 64'({32'd2, 1'b1}));
        if (tx_q_s.size() == 2)
            chk("ovf_small_aa", 64'(tx_q_s[1]), 64'hAA);

        chk("wren_tx_overlap", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
